// File: rtl/mem_access_master_if.sv
// rtl/mem_access_master_if.sv - request/response and memory bus bundle for mem_access_master
interface mem_access_master_if #(
  parameter int WIDTH = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] wr_data;
  logic             mem_write;
  logic [WIDTH-1:0] rd_data;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err, address, wr_data, mem_write
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, address, wr_data, mem_write
  );
endinterface

// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - load/store request to word-aligned big-endian bus cycles
// Sub-word stores are read-modify-write; every output is registered.
module mem_access_master #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  mem_access_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_WRITE,
    S_RESP,
    S_ERR_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       off_q, off_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic             write_q, write_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [WIDTH-1:0] address_q, address_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             mem_write_q, mem_write_d;

  logic             misaligned;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] merged;

  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    byte_lane = bus.rd_data[31:24];
    case (off_q)
      2'd0:    byte_lane = bus.rd_data[31:24];
      2'd1:    byte_lane = bus.rd_data[23:16];
      2'd2:    byte_lane = bus.rd_data[15:8];
      default: byte_lane = bus.rd_data[7:0];
    endcase
    half_lane = off_q[1] ? bus.rd_data[15:0] : bus.rd_data[31:16];

    load_data = bus.rd_data;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_data = bus.rd_data;
    endcase

    merged = bus.rd_data;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  // Output registers load the values belonging to the state being entered.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    signed_d     = signed_q;
    write_d      = write_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    address_d    = address_q;
    wr_data_d    = wr_data_q;
    mem_write_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          off_d    = bus.req_addr[1:0];
          wdata_d  = bus.req_wdata[15:0];
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          write_d  = bus.req_write;
          if (misaligned) begin
            state_d      = S_ERR_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = S_ACCESS;
            address_d = {bus.req_addr[WIDTH-1:2], 2'b00};
            if (bus.req_write && bus.req_size[1]) begin
              mem_write_d = 1'b1;
              wr_data_d   = bus.req_wdata;
            end
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (write_q && size_q[1]) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (write_q) begin
          state_d     = S_WRITE;
          wr_data_d   = merged;
          mem_write_d = 1'b1;
        end else begin
          state_d      = S_RESP;
          resp_rdata_d = load_data;
          resp_valid_d = 1'b1;
        end
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP, S_ERR_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      off_q        <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      address_q    <= '0;
      wr_data_q    <= '0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      address_q    <= address_d;
      wr_data_q    <= wr_data_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.address    = address_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.mem_write  = mem_write_q;

endmodule

// File: tb/tb_mem_access_master.sv
// tb/tb_mem_access_master.sv - randomized scoreboard bench for mem_access_master
module tb_mem_access_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_master_if #(.WIDTH(32)) bus ();

  mem_access_master #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_cnt = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] inport0, inport1, outport, ref_out;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          nwr;
    logic [31:0] waddr;
  } exp_t;

  exp_t sb_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'hFFF8) return inport0;
    if (a == 32'hFFFC) return inport1;
    return mem[a[7:2]];
  endfunction

  // Memory-side environment: registered read, write on the sampling edge.
  always @(posedge clk) begin
    if (bus.mem_write) begin
      if (bus.address == 32'hFFFC) outport <= bus.wr_data;
      else mem[bus.address[7:2]] <= bus.wr_data;
    end
    bus.rd_data <= mem_rd(bus.address);
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (a == 32'hFFF8) return inport0;
    if (a == 32'hFFFC) return inport1;
    return ref_mem[a[7:2]];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.mem_write) begin
        wr_cnt++;
        if (sb_q.size() > 0) check("wr_addr", bus.address, sb_q[0].waddr);
        else begin
          tests++; fails++;
          $display("FAIL wr_unexpected: got mem_write=1 want no write");
        end
      end
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL resp_unexpected: got resp_valid=1 want idle");
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", bus.resp_err, e.err);
          check("latency", cyc - e.acc + 1, e.lat);
          check("write_count", wr_cnt, e.nwr);
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int n = 0;
    int sh;
    logic [31:0] al, w, m, v;
    logic mis;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got req_ready=0 want 1");
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    al  = {a[31:2], 2'b00};
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    w   = ref_rd(al);
    sh  = (sz == 2'b00) ? 8 * (3 - int'(a[1:0])) : 16 * (1 - int'(a[1]));
    e.acc = cyc;
    e.waddr = al;
    e.rdata = 32'h0;
    e.err = 1'b0;
    e.nwr = 0;
    if (mis) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (wr) begin
      e.nwr = 1;
      if (sz[1]) begin
        e.lat = 2;
        v = wd;
      end else begin
        e.lat = 4;
        m = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        v = (w & ~m) | ((wd << sh) & m);
      end
      if (al == 32'hFFFC) ref_out = v;
      else ref_mem[al[7:2]] = v;
    end else begin
      e.lat = 3;
      if (sz == 2'b00) begin
        v = (w >> sh) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
        v = (w >> sh) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      e.rdata = v;
    end
    sb_q.push_back(e);
    // Garbage held for one busy cycle must be ignored.
    bus.req_write = $urandom_range(0, 1);
    bus.req_size  = 2'($urandom_range(0, 3));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    logic wr;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'hF0F0F0F0; ref_mem[1] = 32'hF0F0F0F0;
    inport0 = $urandom; inport1 = $urandom; outport = 32'h0; ref_out = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_address", bus.address, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_mem_write", bus.mem_write, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", bus.req_ready, 1);

    issue(1, 2'b10, 0, 32'h0, 32'h0A0A0A0A);
    issue(0, 2'b10, 0, 32'h0, 32'h0);
    drain();
    check("mem0_word", mem[0], 32'h0A0A0A0A);
    issue(1, 2'b00, 0, 32'h5, 32'hFF);
    drain();
    check("mem1_sb", mem[1], 32'hF0FFF0F0);
    issue(0, 2'b00, 1, 32'h5, 32'h0);
    issue(0, 2'b00, 0, 32'h5, 32'h0);
    issue(0, 2'b01, 1, 32'h6, 32'h0);
    issue(0, 2'b10, 0, 32'h2, 32'h0);
    issue(0, 2'b01, 0, 32'h7, 32'h0);
    issue(1, 2'b10, 0, 32'hFFFC, 32'h00001111);
    drain();
    check("outport_sw", outport, 32'h00001111);
    inport0 = 32'h00010000;
    issue(0, 2'b10, 0, 32'hFFF8, 32'h0);
    issue(1, 2'b11, 0, 32'h8, 32'h12345678);
    drain();

    for (int k = 0; k < 150; k++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = wr ? 32'hFFFC + $urandom_range(0, 3) : 32'hFFF8 + $urandom_range(0, 7);
      else
        a = $urandom_range(0, 255);
      issue(wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    check("outport_final", outport, ref_out);

    // Reset while a byte store sits in WAIT: the write must never happen.
    ref_mem[1] = mem[1];
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h4; bus.req_wdata = 32'h5A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_mem_write", bus.mem_write, 0);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_address", bus.address, 0);
    check("midrst_wr_data", bus.wr_data, 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_hold_mem_write", bus.mem_write, 0);
    end
    rst = 1'b0;
    wr_cnt = 0;
    @(posedge clk); #1;
    check("midrst_ready_after", bus.req_ready, 1);
    check("midrst_mem1_unchanged", mem[1], ref_mem[1]);
    issue(0, 2'b10, 0, 32'h4, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator side of the memory-mapped bus served by `memory`. Drives `address`, `wr_data` and `mem_write`, and consumes `rd_data`.
- Sits between the datapath load/store logic and `memory`.
- Turns one load/store request (byte, half or word; signed or unsigned) into the correct word-aligned bus cycles.
- Sub-word stores are done as read-modify-write.

Parameters:
- WIDTH, 32, data/address width. Only 32 is supported; byte lanes are fixed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WIDTH  load result; 0 for stores.
- resp_err  out  1  misaligned request; qualified by resp_valid.
- address  out  WIDTH  to memory; low two bits always 00.
- wr_data  out  WIDTH  to memory.
- mem_write  out  1  to memory.
- rd_data  in  WIDTH  from memory; valid in the cycle after the edge that samples `address`.

Behaviour:
- Reset:
  - State IDLE; req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, address=0, wr_data=0, mem_write=0.
  - All outputs come from registers, so rst deasserts mem_write immediately.
  - req_ready rises at the first clk edge after rst falls.
- Accept: on an edge with req_valid && req_ready. Latch addr, wdata, size, signed and write; req_ready drops.
- Byte order is big-endian:
  - Byte offset 0 → bits[31:24], offset 3 → bits[7:0].
  - Half offset 0 → bits[31:16], offset 2 → bits[15:0].
- Misaligned request (half with addr[0]=1, or word with addr[1:0]≠00):
  - No bus activity; mem_write is never asserted.
  - ERR_RESP cycle follows: resp_valid=1, resp_err=1, resp_rdata=0.
- States and transitions:
  - IDLE → ACCESS (or ERR_RESP) on accept.
  - ACCESS: address={addr[31:2],2'b00}.
    - Word store: mem_write=1, wr_data=wdata, → RESP.
    - Load or sub-word store: mem_write=0, → WAIT.
  - WAIT: rd_data is valid this cycle.
    - Load: extract the lane, zero- or sign-extend, register it into resp_rdata, → RESP.
    - Sub-word store: merge wdata's low byte/half into the selected lane of rd_data, register as wr_data, → WRITE.
  - WRITE: mem_write=1, same address, → RESP.
  - RESP / ERR_RESP: resp_valid=1 for exactly one cycle, → IDLE; req_ready returns the next cycle.
- Latency from accept edge to the resp_valid cycle:
  - Word store: 2 cycles.
  - Load: 3 cycles.
  - Sub-word store: 4 cycles.
  - Misaligned: 1 cycle.
- Busy behaviour: req_valid is ignored while req_ready=0. The response cannot be back-pressured.
- mem_write is high in at most one cycle per request and never in IDLE, WAIT or RESP.
- Memory-mapped ports are reached transparently through the normal word path:
  - 0xFFF8 reads inport0.
  - 0xFFFC reads inport1 and writes outport.
  - No special casing in this block.
- Reset mid-operation: state returns to IDLE, the pending request is dropped, and no write completes unless mem_write was already sampled.

Test Plan:
- Word store 0x0A0A0A0A to 0x0, then word load from 0x0 → mem_write high for exactly 1 cycle with address=0x0; load resp_rdata=0x0A0A0A0A 3 cycles after accept.
- Word 0x4 holds 0xF0F0F0F0; sb 0xFF to 0x5 → read cycle then write cycle at address 0x4 with wr_data=0xF0FFF0F0; resp_valid 4 cycles after accept.
- Load byte 0x5: signed → 0xFFFFFFFF, unsigned → 0x000000FF. Load half 0x6 signed → 0xFFFFF0F0.
- lw at 0x2 and lh at 0x7 → resp_err=1, resp_rdata=0, mem_write never asserted, 1-cycle latency.
- Word store 0x00001111 to 0xFFFC → outport=0x00001111. inport0 loaded with 0x00010000 (inport_0_en pulse), then lw 0xFFF8 → resp_rdata=0x00010000.
- Assert rst during WAIT of an sb to 0x4 → mem_write stays 0, word 0x4 unchanged, all outputs 0, req_ready=1 one edge after rst release.
